// File: rtl/rffe_master_pkg.sv
// Shared constants, state encoding and parity helper for the RFFE bus master.
package rffe_master_pkg;

    localparam int SA_W   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [2:0] RFFE_CMD_REG_WR = 3'b010;
    localparam logic [2:0] RFFE_CMD_REG_RD = 3'b011;

    localparam int RFFE_CMD_BITS  = 13;
    localparam int RFFE_DATA_BITS = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SSC_H,
        ST_SSC_L,
        ST_CMD,
        ST_WDATA,
        ST_RPARK,
        ST_RDATA,
        ST_PARK,
        ST_DONE
    } rffe_state_t;

    // Odd parity: the returned bit makes the total count of ones odd.
    function automatic logic odd_par(input logic [11:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/rffe_tick_gen.sv
// Half-period timer for SCLK: counts 0..HALF_DIV-1 while enabled and tracks
// which half (high/low) of the SCLK period is in progress.
module rffe_tick_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic half_tick,
    output logic phase
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_tick = en && (cnt == LAST);

    // phase=1 marks the high half; every period starts high.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rffe_master.sv
// RFFE master: serialises one register write/read per command onto SCLK/SDATA
// and returns a one-cycle response with read data and parity status.
module rffe_master
    import rffe_master_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vd,
    output logic              cmd_rdy,
    input  logic              cmd_rw,
    input  logic [SA_W-1:0]   cmd_sa,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_vd,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              busy,
    output logic              sclk,
    output logic              sdata_o,
    output logic              sdata_oe,
    input  logic              sdata_i
);

    localparam logic [3:0] CMD_LAST  = 4'(RFFE_CMD_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(RFFE_DATA_BITS - 1);

    rffe_state_t state, state_n;
    logic        half_tick, phase, period_end, accept;
    logic        is_read;
    logic [21:0] tx;
    logic [8:0]  rx;
    logic [3:0]  bit_cnt;
    logic        sclk_d, sdo_d, oe_d;
    logic [11:0] cmd_word;

    rffe_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (state != ST_IDLE),
        .half_tick (half_tick),
        .phase     (phase)
    );

    assign period_end = half_tick && !phase;
    assign accept     = cmd_vd && cmd_rdy;
    assign cmd_word   = {cmd_sa, (cmd_rw ? RFFE_CMD_REG_RD : RFFE_CMD_REG_WR), cmd_addr};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
        oe_d    = 1'b1;
        case (state)
            ST_IDLE:  if (accept) state_n = ST_SSC_H;
            ST_SSC_H: begin
                sdo_d = 1'b1;
                if (period_end) state_n = ST_SSC_L;
            end
            ST_SSC_L: if (period_end) state_n = ST_CMD;
            ST_CMD: begin
                sclk_d = phase;
                sdo_d  = tx[21];
                if (period_end && bit_cnt == CMD_LAST)
                    state_n = is_read ? ST_RPARK : ST_WDATA;
            end
            ST_WDATA: begin
                sclk_d = phase;
                sdo_d  = tx[21];
                if (period_end && bit_cnt == DATA_LAST) state_n = ST_PARK;
            end
            ST_RPARK: begin
                sclk_d = phase;
                oe_d   = phase;
                if (period_end) state_n = ST_RDATA;
            end
            ST_RDATA: begin
                sclk_d = phase;
                oe_d   = 1'b0;
                if (period_end && bit_cnt == DATA_LAST) state_n = ST_PARK;
            end
            ST_PARK: begin
                sclk_d = phase;
                oe_d   = phase && !is_read;
                if (period_end) state_n = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Pins are registered from the current-state decode, so they trail the
    // FSM by one clk; the read sample point is aligned to the pin, i.e. the
    // last clk in which the registered sclk is still high.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_read <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                is_read <= cmd_rw;
                tx      <= {cmd_word, odd_par(cmd_word),
                            cmd_wdata, odd_par({4'b0000, cmd_wdata})};
                rx      <= '0;
                bit_cnt <= '0;
            end else if (period_end &&
                         (state == ST_CMD || state == ST_WDATA || state == ST_RDATA)) begin
                bit_cnt <= (state_n != state) ? 4'd0 : bit_cnt + 4'd1;
                if (state != ST_RDATA) tx <= {tx[20:0], 1'b0};
            end
            if (state == ST_RDATA && !phase && sclk) rx <= {rx[7:0], sdata_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rdy   <= 1'b0;
            busy      <= 1'b0;
            rsp_vd    <= 1'b0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
            sclk      <= 1'b0;
            sdata_o   <= 1'b0;
            sdata_oe  <= 1'b1;
        end else begin
            cmd_rdy  <= (state_n == ST_IDLE);
            busy     <= (state_n != ST_IDLE);
            sclk     <= sclk_d;
            sdata_o  <= sdo_d;
            sdata_oe <= oe_d;
            rsp_vd   <= (state == ST_DONE);
            if (state == ST_DONE) begin
                rsp_rdata <= is_read ? rx[8:1] : 8'h00;
                rsp_perr  <= is_read && !(^rx);
            end
        end
    end

endmodule

// File: tb/tb_rffe_master.sv
// Bench for rffe_master: two instances (HALF_DIV=2 and HALF_DIV=1) behind one
// selected view, a slave that answers reads, and a frame-level reference model.
module tb_rffe_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_vd, cmd_rw, sdata_i, sel;
    logic [3:0] cmd_sa;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic [1:0] rdy_w, vd_w, perr_w, busy_w, sclk_w, sdo_w, oe_w;
    logic [7:0] rdata0, rdata1;
    logic       v_rdy, v_vd, v_perr, v_busy, v_sclk, v_sdo, v_oe;
    logic [7:0] v_rdata;

    rffe_master #(.HALF_DIV(2)) u_h2 (
        .clk(clk), .rst(rst), .cmd_vd(cmd_vd & ~sel), .cmd_rdy(rdy_w[0]),
        .cmd_rw(cmd_rw), .cmd_sa(cmd_sa), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vd(vd_w[0]), .rsp_rdata(rdata0), .rsp_perr(perr_w[0]), .busy(busy_w[0]),
        .sclk(sclk_w[0]), .sdata_o(sdo_w[0]), .sdata_oe(oe_w[0]), .sdata_i(sdata_i)
    );

    rffe_master #(.HALF_DIV(1)) u_h1 (
        .clk(clk), .rst(rst), .cmd_vd(cmd_vd & sel), .cmd_rdy(rdy_w[1]),
        .cmd_rw(cmd_rw), .cmd_sa(cmd_sa), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vd(vd_w[1]), .rsp_rdata(rdata1), .rsp_perr(perr_w[1]), .busy(busy_w[1]),
        .sclk(sclk_w[1]), .sdata_o(sdo_w[1]), .sdata_oe(oe_w[1]), .sdata_i(sdata_i)
    );

    assign v_rdy   = rdy_w[sel];
    assign v_vd    = vd_w[sel];
    assign v_perr  = perr_w[sel];
    assign v_busy  = busy_w[sel];
    assign v_sclk  = sclk_w[sel];
    assign v_sdo   = sdo_w[sel];
    assign v_oe    = oe_w[sel];
    assign v_rdata = sel ? rdata1 : rdata0;

    int n_vec = 0;
    int n_err = 0;

    // Observations of one frame.
    int          obs_lat, obs_rises, obs_ssc, obs_oe0, obs_hi, obs_rdy_early;
    logic [23:0] obs_bits, obs_oes;
    logic [7:0]  obs_rdata;
    logic        obs_perr, obs_rdy_end;

    // Reference-model expectations of one frame.
    int          exp_lat, exp_rises, exp_ssc, exp_oe0, exp_hi;
    logic [23:0] exp_bits, exp_oes;
    logic [7:0]  exp_rdata;
    logic        exp_perr;

    // Frame as the slave sees it on each SCLK rise: command bits, then either
    // write data or turnaround plus slave-driven data, then the park bit.
    task automatic model(input int h, input logic rw, input logic [3:0] sa,
                         input logic [4:0] a, input logic [7:0] wd,
                         input logic [7:0] sb, input logic sp);
        logic [11:0] c;
        logic        b[$];
        logic        e[$];
        c = {sa, (rw ? 3'b011 : 3'b010), a};
        for (int i = 11; i >= 0; i--) begin b.push_back(c[i]); e.push_back(1'b1); end
        b.push_back(($countones(c) % 2) == 0); e.push_back(1'b1);
        if (!rw) begin
            for (int i = 7; i >= 0; i--) begin b.push_back(wd[i]); e.push_back(1'b1); end
            b.push_back(($countones(wd) % 2) == 0); e.push_back(1'b1);
        end else begin
            b.push_back(1'b0); e.push_back(1'b1);
            for (int i = 0; i < 9; i++) begin b.push_back(1'b0); e.push_back(1'b0); end
        end
        b.push_back(1'b0); e.push_back(!rw);
        exp_bits = '0;
        exp_oes  = '0;
        foreach (b[i]) begin
            exp_bits = {exp_bits[22:0], b[i] & e[i]};
            exp_oes  = {exp_oes[22:0], e[i]};
        end
        exp_rises = b.size();
        exp_lat   = (rw ? 52 : 50) * h + 2;
        exp_oe0   = rw ? 21 * h : h;
        exp_ssc   = 2 * h;
        exp_hi    = exp_rises * h;
        exp_rdata = rw ? sb : 8'h00;
        exp_perr  = rw && (sp != (($countones(sb) % 2) == 0));
    endtask

    task automatic send(input logic rw, input logic [3:0] sa, input logic [4:0] a,
                        input logic [7:0] wd, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!v_rdy && t < 300) begin @(negedge clk); t++; end
        cmd_rw = rw; cmd_sa = sa; cmd_addr = a; cmd_wdata = wd; cmd_vd = 1'b1;
        @(posedge clk); #1;
        if (!hold) cmd_vd = 1'b0;
    endtask

    // Watches one frame from the accept edge; acts as the slave for reads.
    task automatic monitor(input int h, input logic rw, input logic [7:0] sb,
                           input logic sp, input int stop_rise);
        int          cyc = 0;
        logic        prev = 1'b0;
        bit          done = 0;
        logic [8:0]  sw;
        sw = {sb, sp};
        obs_lat = -1; obs_rises = 0; obs_ssc = 0; obs_oe0 = 0; obs_hi = 0;
        obs_rdy_early = 0; obs_bits = '0; obs_oes = '0;
        obs_rdata = 8'hxx; obs_perr = 1'bx; obs_rdy_end = 1'b0;
        while (!done && cyc < 60 * h + 20) begin
            @(negedge clk);
            cyc++;
            if (!v_oe) obs_oe0++;
            if (v_sclk) obs_hi++;
            if (obs_rises == 0 && !v_sclk && v_sdo) obs_ssc++;
            if (v_sclk && !prev) begin
                obs_rises++;
                obs_bits = {obs_bits[22:0], v_sdo & v_oe};
                obs_oes  = {obs_oes[22:0], v_oe};
                if (rw && obs_rises >= 15 && obs_rises <= 23) sdata_i = sw[23 - obs_rises];
                if (obs_rises == stop_rise) done = 1;
            end
            prev = v_sclk;
            if (v_vd) begin
                obs_lat = cyc; obs_rdata = v_rdata; obs_perr = v_perr;
                obs_rdy_end = v_rdy; done = 1;
            end else if (v_rdy) begin
                obs_rdy_early++;
            end
        end
        if (stop_rise == 0) sdata_i = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; cmd_vd = 1'b0; sdata_i = 1'b0;
        cmd_rw = 1'b0; cmd_sa = '0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({v_rdy, v_busy, v_vd, v_rdata, v_perr, v_sclk, v_sdo, v_oe} !== 15'b000_00000000_0001) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b busy=%b vd=%b rdata=%h perr=%b sclk=%b sdo=%b oe=%b want 0/0/0/00/0/0/0/1",
                     v_rdy, v_busy, v_vd, v_rdata, v_perr, v_sclk, v_sdo, v_oe);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (v_rdy !== 1'b1 || v_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rdy_after_reset got rdy=%b busy=%b want 1/0", v_rdy, v_busy);
        end
    endtask

    task automatic test_frame(input string name, input logic s, input logic rw,
                              input logic [3:0] sa, input logic [4:0] a, input logic [7:0] wd,
                              input logic [7:0] sb, input logic sp);
        int h;
        sel = s;
        h = s ? 1 : 2;
        model(h, rw, sa, a, wd, sb, sp);
        send(rw, sa, a, wd, 0);
        monitor(h, rw, sb, sp, 0);
        n_vec++;
        if (obs_lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", name, obs_lat, exp_lat);
        end
        n_vec++;
        if (obs_rdata !== exp_rdata || obs_perr !== exp_perr) begin
            n_err++;
            $display("FAIL %s response got rdata=%h perr=%b want rdata=%h perr=%b",
                     name, obs_rdata, obs_perr, exp_rdata, exp_perr);
        end
        n_vec++;
        if (obs_rises !== exp_rises || obs_bits !== exp_bits || obs_oes !== exp_oes) begin
            n_err++;
            $display("FAIL %s wave got rises=%0d bits=%h oes=%h want rises=%0d bits=%h oes=%h",
                     name, obs_rises, obs_bits, obs_oes, exp_rises, exp_bits, exp_oes);
        end
        n_vec++;
        if (obs_ssc !== exp_ssc || obs_oe0 !== exp_oe0 || obs_hi !== exp_hi || obs_rdy_early !== 0) begin
            n_err++;
            $display("FAIL %s timing got ssc=%0d oe0=%0d hi=%0d rdy_early=%0d want ssc=%0d oe0=%0d hi=%0d rdy_early=0",
                     name, obs_ssc, obs_oe0, obs_hi, obs_rdy_early, exp_ssc, exp_oe0, exp_hi);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        model(2, 1'b0, 4'h2, 5'h05, 8'h3C, 8'h00, 1'b0);
        send(1'b0, 4'h2, 5'h05, 8'h3C, 1);
        cmd_rw = 1'b1; cmd_sa = 4'h9; cmd_addr = 5'h11;
        monitor(2, 1'b0, 8'h00, 1'b0, 0);
        n_vec++;
        if (obs_lat !== exp_lat || obs_rdy_early !== 0 || obs_rdy_end !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first got lat=%0d rdy_early=%0d rdy_at_rsp=%b want lat=%0d rdy_early=0 rdy_at_rsp=1",
                     obs_lat, obs_rdy_early, obs_rdy_end, exp_lat);
        end
        n_vec++;
        if (obs_bits !== exp_bits) begin
            n_err++;
            $display("FAIL b2b_first_bits got %h want %h", obs_bits, exp_bits);
        end
        @(posedge clk); #1;
        cmd_vd = 1'b0;
        model(2, 1'b1, 4'h9, 5'h11, 8'h00, 8'hC3, 1'b1);
        monitor(2, 1'b1, 8'hC3, 1'b1, 0);
        n_vec++;
        if (obs_lat !== exp_lat || obs_bits !== exp_bits || obs_rdata !== exp_rdata || obs_perr !== exp_perr) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d bits=%h rdata=%h perr=%b want lat=%0d bits=%h rdata=%h perr=%b",
                     obs_lat, obs_bits, obs_rdata, obs_perr, exp_lat, exp_bits, exp_rdata, exp_perr);
        end
    endtask

    task automatic test_reset_mid_frame();
        int vd_cnt = 0;
        sel = 1'b0;
        send(1'b1, 4'h3, 5'h00, 8'h00, 0);
        monitor(2, 1'b1, 8'h5A, 1'b1, 19);
        n_vec++;
        if (obs_rises !== 19) begin
            n_err++;
            $display("FAIL midrst_reach got rises=%0d want 19", obs_rises);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sdata_i = 1'b0;
        n_vec++;
        if ({v_sclk, v_oe, v_sdo, v_busy, v_vd, v_rdy} !== 6'b010000) begin
            n_err++;
            $display("FAIL midrst_outputs got sclk=%b oe=%b sdo=%b busy=%b vd=%b rdy=%b want 0/1/0/0/0/0",
                     v_sclk, v_oe, v_sdo, v_busy, v_vd, v_rdy);
        end
        repeat (120) begin
            @(negedge clk);
            if (v_vd) vd_cnt++;
        end
        n_vec++;
        if (vd_cnt !== 0 || v_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_quiet got rsp_vd_pulses=%0d rdy=%b want 0/1", vd_cnt, v_rdy);
        end
        test_frame("midrst_recover", 1'b0, 1'b0, 4'hE, 5'h0A, 8'h69, 8'h00, 1'b0);
    endtask

    task automatic test_random(input int n);
        logic       s, rw, sp;
        logic [3:0] sa;
        logic [4:0] a;
        logic [7:0] wd, sb;
        for (int i = 0; i < n; i++) begin
            s  = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            sa = 4'($urandom_range(0, 15));
            a  = 5'($urandom_range(0, 31));
            wd = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            sp = (($countones(sb) % 2) == 0);
            if ($urandom_range(0, 3) == 0) sp = ~sp;
            test_frame("random", s, rw, sa, a, wd, sb, sp);
        end
    endtask

    initial begin
        test_reset();
        test_frame("write_a5", 1'b0, 1'b0, 4'h7, 5'h1C, 8'hA5, 8'h00, 1'b0);
        test_frame("read_5a", 1'b0, 1'b1, 4'h3, 5'h00, 8'h00, 8'h5A, 1'b1);
        test_frame("read_5a_badpar", 1'b0, 1'b1, 4'h3, 5'h00, 8'h00, 8'h5A, 1'b0);
        test_back_to_back();
        test_reset_mid_frame();
        test_frame("hd1_write_ff", 1'b1, 1'b0, 4'h5, 5'h13, 8'hFF, 8'h00, 1'b0);
        test_frame("hd1_read", 1'b1, 1'b1, 4'hA, 5'h1F, 8'h00, 8'h81, 1'b1);
        test_random(12);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
